plant_emulator: RTL
===================

# plant_emulator

Synthesizable closed-loop plant model that sits on the opposite end of the controller's two AXI-Stream links. It consumes control effort from the controller's master output and integrates it into a fixed-point plant state. It optionally adds LFSR pseudo-noise and emits sensor samples on an AXI-Stream master that feeds the controller's slave input. This moves the behavioural physics loop into hardware for on-board closed-loop and hardware-in-the-loop runs.

## Interface
Parameters:
- `W`, 16: sample and effort width, signed.
- `GAIN_SHIFT`, 11: plant gain is 2^-GAIN_SHIFT per tick per effort LSB (≈0.0005).
- `NOISE_BITS`, 4: noise range is [-2^NOISE_BITS, 2^NOISE_BITS-1].
- `SAMPLE_DIV`, 1: ticks occur every SAMPLE_DIV cycles; range 1..255.

Ports:
- `clk` in 1: the single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `enable` in 1: run plant; low parks the FSM in IDLE.
- `clear` in 1: synchronous clear of the state and the held effort.
- `noise_en` in 1: runtime noise gate.
- `s_axis_tdata` in W: signed control effort.
- `s_axis_tvalid` in 1: effort valid.
- `s_axis_tready` out 1: effort accepted.
- `m_axis_tdata` out W: signed sensor sample.
- `m_axis_tvalid` out 1: sample valid.
- `m_axis_tready` in 1: downstream ready.
- `sat` out 1: accumulator currently clamped.
- `drop_cnt` out 8: samples dropped due to backpressure; saturates at 255.

## Operation
- FSM states IDLE and RUN.
  - Reset → IDLE.
  - IDLE→RUN when `enable`=1.
  - RUN→IDLE when `enable`=0; the transition is taken at the next edge.
- In IDLE:
  - `s_axis_tready`=0.
  - No ticks; the tick divider is held at 0.
  - `acc`, `effort` and the LFSR hold their values.
  - A pending output sample stays valid until it is accepted.
- In RUN:
  - `s_axis_tready`=1.
  - Each s-handshake loads `effort` (zero-order hold: the last accepted value is reused every tick).
- Tick: the divider counts 0..SAMPLE_DIV-1 in RUN; a tick fires when the count is SAMPLE_DIV-1. With SAMPLE_DIV=1, every RUN cycle is a tick.
- On a tick:
  - `acc_next` = clamp(`acc` + sext(`effort`)).
  - `acc` is signed, W+GAIN_SHIFT+1 bits.
  - Clamp bounds: [-(2^(W-1))·2^GAIN_SHIFT, (2^(W-1)-1)·2^GAIN_SHIFT].
  - `sat` is registered high when the clamp engaged on the tick and low otherwise.
- Sample formation:
  - `sample` = clampW((`acc_next` >>> GAIN_SHIFT) + `noise`).
  - The shift is arithmetic.
  - The sum is formed at W+1 bits, then clamped to the W-bit signed range.
- Noise:
  - `noise` = sign-extended `lfsr`[NOISE_BITS:0] when `noise_en` and the macro is present; 0 otherwise.
  - The LFSR advances one step per tick.
- Output register:
  - If `m_axis_tvalid`=0, or `m_axis_tready`=1 in the same cycle, the tick loads `sample` and sets valid.
  - Otherwise the held sample is kept unchanged (AXI stability) and `drop_cnt` is incremented.
- `clear`, in any state:
  - `acc`←0, `effort`←0, `sat`←0, divider←0.
  - The output register, LFSR and `drop_cnt` are unaffected.
  - `clear` has priority over a coincident tick and over a coincident s-handshake.

## Timing
- Reset values:
  - `s_axis_tready`=0, `m_axis_tvalid`=0, `m_axis_tdata`=0, `sat`=0, `drop_cnt`=0.
  - `acc`=0, `effort`=0, LFSR=16'hACE1, FSM=IDLE.
- Effort latency: an effort accepted at edge k is first integrated on the first tick at edge ≥k+1. With SAMPLE_DIV=1, the sample appears valid after edge k+1.
- `m_axis_tvalid` falls on the edge where valid&ready holds and no tick occurs. Valid stays high across back-to-back handshake+tick cycles.
- `reset_n` asserted mid-transfer: outputs take their reset values immediately (asynchronously); any in-flight sample is discarded.
- `enable` falling with a tick in the same cycle: the tick completes, then the FSM enters IDLE.

## Configuration
- `PLANT_NOISE_EN` defined:
  - LFSR instantiated.
  - Noise is added to samples, gated by `noise_en`.
- `PLANT_NOISE_EN` undefined:
  - No LFSR logic; `noise`=0.
  - `noise_en` is ignored.
  - Samples are the pure clamped integer state.

## Structure
- `plant_pkg` contains:
  - The state enum (IDLE, RUN).
  - LFSR seed 16'hACE1 and taps x^16+x^14+x^13+x^11 (Galois).
  - The signed clamp function.
- Sub-module `plant_lfsr`: 16-bit Galois LFSR with step enable and async active-low reset to the seed. It is instantiated only under `PLANT_NOISE_EN`.

## Test plan
- Reset: hold `reset_n`=0 → all outputs at reset values; `s_axis_tready`=0.
- Ramp: noise off, `enable`=1, one effort of 2048, `m_axis_tready`=1 → samples 1, 2, 3, … (+1 per cycle).
- Backpressure: `m_axis_tready`=0 for 10 ticks → `m_axis_tdata` stable at its first value; `drop_cnt`=9.
- Saturation: effort 16'h7FFF held → samples stick at 32767 and `sat`=1. Then effort -32768 → samples decrease and `sat` drops.
- Noise bounds: zero effort, `noise_en`=1, NOISE_BITS=4, 1000 samples → all values in [-16, 15] and not constant. Without the macro → all 0.
- `clear`/`enable`: `clear` pulse mid-ramp → next sample 0+effort step. `enable`=0 → `s_axis_tready`=0 and no new samples.

Source files
------------

// File: rtl/plant_pkg.sv
// Shared types, LFSR constants and the signed clamp helper for the plant emulator.
package plant_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Galois, right-shifting form of x^16 + x^14 + x^13 + x^11
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic signed [63:0] clamp_s(
        input logic signed [63:0] x,
        input logic signed [63:0] lo,
        input logic signed [63:0] hi
    );
        if (x < lo) begin
            return lo;
        end else if (x > hi) begin
            return hi;
        end
        return x;
    endfunction

endpackage

// File: rtl/plant_lfsr.sv
// 16-bit Galois LFSR that steps once per enabled cycle and resets asynchronously to the seed.
import plant_pkg::*;

module plant_lfsr (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        step_i,
    output logic [15:0] lfsr_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : '0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= LFSR_SEED;
        end else if (step_i) begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/plant_emulator.sv
// Fixed-point integrating plant driven by AXI-Stream effort and emitting AXI-Stream sensor samples.
// Define PLANT_NOISE_EN to build in LFSR pseudo-noise gated at runtime by noise_en.
import plant_pkg::*;

module plant_emulator #(
    parameter int W          = 16,
    parameter int GAIN_SHIFT = 11,
    parameter int NOISE_BITS = 4,
    parameter int SAMPLE_DIV = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         enable,
    input  logic         clear,
    input  logic         noise_en,
    input  logic [W-1:0] s_axis_tdata,
    input  logic         s_axis_tvalid,
    output logic         s_axis_tready,
    output logic [W-1:0] m_axis_tdata,
    output logic         m_axis_tvalid,
    input  logic         m_axis_tready,
    output logic         sat,
    output logic [7:0]   drop_cnt
);

    localparam int AW = W + GAIN_SHIFT + 1;
    localparam logic signed [63:0] ACC_MAX  = ((64'sd1 <<< (W - 1)) - 64'sd1) <<< GAIN_SHIFT;
    localparam logic signed [63:0] ACC_MIN  = -(64'sd1 <<< (W - 1 + GAIN_SHIFT));
    localparam logic signed [63:0] SAMP_MAX = (64'sd1 <<< (W - 1)) - 64'sd1;
    localparam logic signed [63:0] SAMP_MIN = -(64'sd1 <<< (W - 1));
    localparam logic [7:0]         DIV_LAST = 8'(SAMPLE_DIV - 1);

    state_e state_q, state_d;

    logic [7:0]           div_q, div_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic [W-1:0]         effort_q, effort_d;
    logic                 sat_q, sat_d;
    logic                 tvalid_q, tvalid_d;
    logic [W-1:0]         tdata_q, tdata_d;
    logic [7:0]           drop_q, drop_d;

    logic                 run;
    logic                 tick;
    logic                 s_hs;
    logic                 clamp_hit;
    logic signed [63:0]   acc_sum64;
    logic signed [63:0]   acc_next64;
    logic signed [63:0]   shifted64;
    logic signed [63:0]   noise64;
    logic signed [63:0]   samp_sum64;
    logic signed [63:0]   samp64;
    logic [W-1:0]         sample;
    logic                 unused_bits;

`ifdef PLANT_NOISE_EN
    logic [15:0] lfsr_w;

    plant_lfsr u_lfsr (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .step_i (tick),
        .lfsr_o (lfsr_w)
    );

    always_comb begin
        noise64 = '0;
        if (noise_en) begin
            noise64 = {{(64 - NOISE_BITS - 1){lfsr_w[NOISE_BITS]}}, lfsr_w[NOISE_BITS:0]};
        end
    end

    assign unused_bits = ^{samp64[63:W], lfsr_w};
`else
    assign noise64     = '0;
    assign unused_bits = ^{samp64[63:W], noise_en};
`endif

    // FSM: state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable)  state_d = RUN;
            RUN:     if (!enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        run           = (state_q == RUN);
        s_axis_tready = run;
    end

    assign s_hs = s_axis_tvalid && s_axis_tready;
    assign tick = run && !clear && (div_q == DIV_LAST);

    always_comb begin
        acc_sum64  = {{(64 - AW){acc_q[AW-1]}}, acc_q}
                   + {{(64 - W){effort_q[W-1]}}, effort_q};
        acc_next64 = clamp_s(acc_sum64, ACC_MIN, ACC_MAX);
        clamp_hit  = (acc_sum64 < ACC_MIN) || (acc_sum64 > ACC_MAX);
        shifted64  = acc_next64 >>> GAIN_SHIFT;
        samp_sum64 = shifted64 + noise64;
        samp64     = clamp_s(samp_sum64, SAMP_MIN, SAMP_MAX);
        sample     = samp64[W-1:0];
    end

    always_comb begin
        div_d    = div_q;
        acc_d    = acc_q;
        effort_d = effort_q;
        sat_d    = sat_q;
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        drop_d   = drop_q;

        // clear wins over the tick and the effort handshake; the output side is left alone
        if (clear) begin
            div_d    = '0;
            acc_d    = '0;
            effort_d = '0;
            sat_d    = 1'b0;
        end else if (run) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + 8'd1;
            if (s_hs) begin
                effort_d = s_axis_tdata;
            end
            if (tick) begin
                acc_d = acc_next64[AW-1:0];
                sat_d = clamp_hit;
            end
        end else begin
            div_d = '0;
        end

        if (tick) begin
            if (!tvalid_q || m_axis_tready) begin
                tdata_d  = sample;
                tvalid_d = 1'b1;
            end else if (drop_q != '1) begin
                drop_d = drop_q + 8'd1;
            end
        end else if (tvalid_q && m_axis_tready) begin
            tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q    <= '0;
            acc_q    <= '0;
            effort_q <= '0;
            sat_q    <= 1'b0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            drop_q   <= '0;
        end else begin
            div_q    <= div_d;
            acc_q    <= acc_d;
            effort_q <= effort_d;
            sat_q    <= sat_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            drop_q   <= drop_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign sat           = sat_q;
    assign drop_cnt      = drop_q;

endmodule
